clkdv_gen: RTL and testbench



---
 rtl/clkdv_pkg.sv | 23 ++
 rtl/clkdv_phase_cnt.sv | 53 +++++
 rtl/clkdv_gen.sv | 107 ++++++++++
 tb/tb_clkdv_gen.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/clkdv_pkg.sv
// Shared types and helpers for the clkdv_gen clock-divide generator.
package clkdv_pkg;

  typedef enum logic [1:0] {
    ST_LOCKING,
    ST_LOCKED,
    ST_SWITCH
  } state_e;

  localparam int MIN_DIVIDE = 2;

  // Fixed arithmetic width so the helper serves any DIV_WIDTH up to 16.
  localparam int CALC_WIDTH = 16;

  // Number of high cycles per CLKDV period for ratio n.
  function automatic logic [CALC_WIDTH-1:0] high_cycles(input logic [CALC_WIDTH-1:0] n,
                                                        input logic                  dcc_en);
    logic [CALC_WIDTH-1:0] h;
    h = dcc_en ? (n >> 1) : CALC_WIDTH'(1);
    return h;
  endfunction

endpackage

// File: rtl/clkdv_phase_cnt.sv
// Phase counter for the divided clock: wraps every `ratio` cycles and
// produces registered CLKDV, its inverse and a period-start enable.
module clkdv_phase_cnt
  import clkdv_pkg::*;
#(
  parameter int DIV_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIV_WIDTH-1:0] ratio,
  input  logic                 dcc_en,
  output logic                 clkdv,
  output logic                 clkdv180,
  output logic                 clkdv_ce,
  output logic                 end_of_period
);

  logic [DIV_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  clkdv_q, clkdv_d;
  logic                  clkdv180_q, clkdv180_d;
  logic                  ce_q, ce_d;
  logic [CALC_WIDTH-1:0] high;

  // NOTE: every always_comb output gets a value before any branch, so no latch is inferred.
  always_comb begin
    high          = high_cycles(CALC_WIDTH'(ratio), dcc_en);
    end_of_period = (cnt_q >= ratio - 1'b1);
    cnt_d         = end_of_period ? '0 : cnt_q + 1'b1;
    clkdv_d       = (CALC_WIDTH'(cnt_q) < high);
    clkdv180_d    = ~clkdv_d;
    ce_d          = (cnt_q == '0);
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      clkdv_q    <= 1'b0;
      clkdv180_q <= 1'b1;
      ce_q       <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      clkdv_q    <= clkdv_d;
      clkdv180_q <= clkdv180_d;
      ce_q       <= ce_d;
    end
  end

  assign clkdv    = clkdv_q;
  assign clkdv180 = clkdv180_q;
  assign clkdv_ce = ce_q;

endmodule

// File: rtl/clkdv_gen.sv
// Runtime-reprogrammable clock-divide generator: ratio change handshake,
// lock tracking and a glitch-free switch at the divider period boundary.
module clkdv_gen
  import clkdv_pkg::*;
#(
  parameter int DIV_WIDTH             = 4,
  parameter int DEFAULT_DIVIDE        = 2,
  parameter int LOCK_CYCLES           = 16,
  parameter     DUTY_CYCLE_CORRECTION = "TRUE"
) (
  input  logic                 CLKIN,
  input  logic                 RST,
  input  logic                 DIV_REQ,
  input  logic [DIV_WIDTH-1:0] DIV_VAL,
  output logic                 DIV_ACK,
  output logic                 DIV_ERR,
  output logic [DIV_WIDTH-1:0] DIV_CUR,
  output logic                 CLKDV,
  output logic                 CLKDV180,
  output logic                 CLKDV_CE,
  output logic                 LOCKED
);

  localparam logic DCC_EN = (DUTY_CYCLE_CORRECTION == "TRUE");
  localparam int   LOCK_W = (LOCK_CYCLES > 2) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);

  state_e               state_q, state_d;
  logic [DIV_WIDTH-1:0] div_cur_q, div_cur_d;
  logic [DIV_WIDTH-1:0] pending_q, pending_d;
  logic [LOCK_W-1:0]    lock_cnt_q, lock_cnt_d;
  logic                 ack_q, ack_d;
  logic                 err_q, err_d;
  logic                 end_of_period;

  always_comb begin
    state_d    = state_q;
    div_cur_d  = div_cur_q;
    pending_d  = pending_q;
    lock_cnt_d = lock_cnt_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      ST_LOCKING: begin
        if (lock_cnt_q == LOCK_LAST) state_d = ST_LOCKED;
        else                         lock_cnt_d = lock_cnt_q + 1'b1;
      end
      ST_LOCKED: begin
        if (DIV_REQ) begin
          ack_d = 1'b1;
          if (DIV_VAL < DIV_WIDTH'(MIN_DIVIDE)) begin
            err_d = 1'b1;
          end else begin
            pending_d = DIV_VAL;
            state_d   = ST_SWITCH;
          end
        end
      end
      ST_SWITCH: begin
        // Loading only on the wrap edge keeps the old period intact: no runt pulse.
        if (end_of_period) begin
          div_cur_d  = pending_q;
          lock_cnt_d = '0;
          state_d    = ST_LOCKING;
        end
      end
      default: state_d = ST_LOCKING;
    endcase
  end

  always_ff @(posedge CLKIN) begin
    if (RST) begin
      state_q    <= ST_LOCKING;
      div_cur_q  <= DIV_WIDTH'(DEFAULT_DIVIDE);
      pending_q  <= '0;
      lock_cnt_q <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_cur_q  <= div_cur_d;
      pending_q  <= pending_d;
      lock_cnt_q <= lock_cnt_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
    end
  end

  clkdv_phase_cnt #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_phase_cnt (
    .clk          (CLKIN),
    .rst          (RST),
    .ratio        (div_cur_q),
    .dcc_en       (DCC_EN),
    .clkdv        (CLKDV),
    .clkdv180     (CLKDV180),
    .clkdv_ce     (CLKDV_CE),
    .end_of_period(end_of_period)
  );

  assign DIV_ACK = ack_q;
  assign DIV_ERR = err_q;
  assign DIV_CUR = div_cur_q;
  assign LOCKED  = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_clkdv_gen.sv
// Directed bench for clkdv_gen: one duty-corrected and one single-high-cycle
// instance driven by the same stimulus, checked against hand-derived values.
module tb_clkdv_gen;

  localparam int W = 4;

  logic         CLKIN   = 1'b0;
  logic         RST     = 1'b1;
  logic         DIV_REQ = 1'b0;
  logic [W-1:0] DIV_VAL = '0;

  logic         ack_t, err_t, dv_t, dv180_t, ce_t, lk_t;
  logic [W-1:0] cur_t;
  logic         ack_f, err_f, dv_f, dv180_f, ce_f, lk_f;
  logic [W-1:0] cur_f;

  int total = 0;
  int bad   = 0;

  clkdv_gen #(
    .DIV_WIDTH(W), .DEFAULT_DIVIDE(2), .LOCK_CYCLES(16), .DUTY_CYCLE_CORRECTION("TRUE")
  ) u_dut (
    .CLKIN(CLKIN), .RST(RST), .DIV_REQ(DIV_REQ), .DIV_VAL(DIV_VAL),
    .DIV_ACK(ack_t), .DIV_ERR(err_t), .DIV_CUR(cur_t), .CLKDV(dv_t),
    .CLKDV180(dv180_t), .CLKDV_CE(ce_t), .LOCKED(lk_t)
  );

  clkdv_gen #(
    .DIV_WIDTH(W), .DEFAULT_DIVIDE(2), .LOCK_CYCLES(16), .DUTY_CYCLE_CORRECTION("FALSE")
  ) u_dut_f (
    .CLKIN(CLKIN), .RST(RST), .DIV_REQ(DIV_REQ), .DIV_VAL(DIV_VAL),
    .DIV_ACK(ack_f), .DIV_ERR(err_f), .DIV_CUR(cur_f), .CLKDV(dv_f),
    .CLKDV180(dv180_f), .CLKDV_CE(ce_f), .LOCKED(lk_f)
  );

  always #5 CLKIN = ~CLKIN;

  task automatic tick();
    @(posedge CLKIN);
    #1;
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_vec(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // dv: CLKDV of the duty-corrected instance, dvf: CLKDV of the other one.
  task automatic check_outs(input string tag, input logic dv, input logic dvf, input logic ce,
                            input logic lk, input logic ack, input logic err,
                            input logic [W-1:0] cur);
    check_bit({tag, " clkdv"},      dv_t,    dv);
    check_bit({tag, " clkdv180"},   dv180_t, ~dv);
    check_bit({tag, " ce"},         ce_t,    ce);
    check_bit({tag, " locked"},     lk_t,    lk);
    check_bit({tag, " ack"},        ack_t,   ack);
    check_bit({tag, " err"},        err_t,   err);
    check_vec({tag, " cur"},        cur_t,   cur);
    check_bit({tag, " clkdv_f"},    dv_f,    dvf);
    check_bit({tag, " clkdv180_f"}, dv180_f, ~dvf);
    check_bit({tag, " ce_f"},       ce_f,    ce);
    check_bit({tag, " locked_f"},   lk_f,    lk);
    check_bit({tag, " ack_f"},      ack_f,   ack);
    check_bit({tag, " err_f"},      err_f,   err);
    check_vec({tag, " cur_f"},      cur_f,   cur);
  endtask

  // Ratio 2 after reset release: 1,0,1,0... with LOCKED on the 16th edge.
  task automatic release_check(input string ph);
    for (int e = 1; e <= 16; e++) begin
      tick();
      check_outs($sformatf("%s e%0d", ph, e), (e % 2) == 1, (e % 2) == 1, (e % 2) == 1,
                 e == 16, 1'b0, 1'b0, W'(2));
    end
  endtask

  initial begin
    // Reset state
    RST = 1'b1;
    tick();
    tick();
    check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, W'(2));

    RST = 1'b0;
    release_check("rel");

    // Illegal ratios 0 and 1: ACK+ERR, nothing else changes
    for (int k = 0; k < 2; k++) begin
      DIV_VAL = W'(k);
      DIV_REQ = 1'b1;
      tick();
      check_outs($sformatf("err_ack v%0d", k), 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, W'(2));
      DIV_REQ = 1'b0;
      tick();
      check_outs($sformatf("err_idle v%0d", k), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, W'(2));
    end

    // Ratio 5, request held high through SWITCH and LOCKING
    DIV_VAL = W'(5);
    DIV_REQ = 1'b1;
    tick();
    check_outs("acc5", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, W'(2));
    tick();
    check_outs("load5", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, W'(5));
    for (int m = 1; m <= 16; m++) begin
      int ph;
      ph = (m - 1) % 5;
      check_outs_wrap: begin
        tick();
        check_outs($sformatf("div5 m%0d", m), ph < 2, ph == 0, ph == 0, m == 16,
                   1'b0, 1'b0, W'(5));
      end
    end
    DIV_REQ = 1'b0;
    for (int m = 17; m <= 19; m++) begin
      int ph;
      ph = (m - 1) % 5;
      tick();
      check_outs($sformatf("div5 m%0d", m), ph < 2, ph == 0, ph == 0, 1'b1,
                 1'b0, 1'b0, W'(5));
    end

    // Ratio 3 accepted on the last cycle of a period: load waits a full period
    DIV_VAL = W'(3);
    DIV_REQ = 1'b1;
    tick();
    check_outs("acc3", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, W'(5));
    DIV_REQ = 1'b0;
    for (int m = 0; m < 4; m++) begin
      tick();
      check_outs($sformatf("hold3 m%0d", m), m < 2, m == 0, m == 0, 1'b0,
                 1'b0, 1'b0, W'(5));
    end
    tick();
    check_outs("load3", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, W'(3));
    for (int m = 1; m <= 16; m++) begin
      int ph;
      ph = (m - 1) % 3;
      tick();
      check_outs($sformatf("div3 m%0d", m), ph == 0, ph == 0, ph == 0, m == 16,
                 1'b0, 1'b0, W'(3));
    end

    // Reset while a ratio-7 switch is pending
    DIV_VAL = W'(7);
    DIV_REQ = 1'b1;
    tick();
    check_outs("acc7", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, W'(3));
    DIV_REQ = 1'b0;
    RST     = 1'b1;
    tick();
    check_outs("rst_sw", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, W'(2));
    RST = 1'b0;
    release_check("rel2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
